tx_bram_pkt_reader: RTL and testbench
=====================================

Name: tx_bram_pkt_reader

Overview:
- Read-side engine for the TX packet buffer dual-port BRAM.
- Drains a packet of NUM words from the BRAM read port, starting at a given word address.
- Presents the words as a valid/ready stream toward the TX baseband pipeline, tagging the final word with last.
- Absorbs the BRAM read latency and downstream backpressure in a small credit-controlled skid FIFO, so no read data is ever lost.

Parameters:
- DATA_WIDTH, 64, BRAM word and stream width.
- ADDR_WIDTH, 10, BRAM word-address width.
- READ_LATENCY, 1, BRAM read latency in cycles, from bram_en/bram_addr to bram_dout valid; legal values 1..4.
- FIFO_DEPTH, READ_LATENCY+2, skid FIFO entries; must be at least READ_LATENCY+1.

Ports:
- clk  in  1  single clock for all logic and the BRAM read port.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a packet; sampled only in IDLE.
- start_addr  in  ADDR_WIDTH  first word address, latched on start.
- num_words  in  ADDR_WIDTH+1  packet length in words, 0..2^ADDR_WIDTH, latched on start.
- abort  in  1  synchronous flush request; return to IDLE.
- busy  out  1  high from the cycle after an accepted start until completion or abort.
- done  out  1  one-cycle pulse on completion.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_WIDTH  BRAM read address.
- bram_dout  in  DATA_WIDTH  BRAM read data, valid READ_LATENCY cycles after bram_en.
- m_tdata  out  DATA_WIDTH  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  high with the final word of the packet.

Behaviour:
- Reset values: busy=0, done=0, bram_en=0, bram_addr=0, m_tvalid=0, m_tlast=0, m_tdata=0. FIFO empty, in-flight tracker cleared, FSM in IDLE.
- FSM states:
  - IDLE: on start with num_words>0, latch the address and remaining=num_words, go to READ. On start with num_words=0, pulse done the next cycle, stay IDLE, no read issued and no beat produced. start is ignored in every other state.
  - READ: each cycle, issue a read (bram_en=1, bram_addr=current address, address+1 modulo 2^ADDR_WIDTH, remaining-1) only when inflight+fifo_count < FIFO_DEPTH and remaining>0. When the last read is issued, go to DRAIN.
  - DRAIN: wait until inflight=0 and FIFO empty, then go to IDLE.
- In-flight tracking: a READ_LATENCY-deep shift register of {valid,last} flags. An issued read's flag emerges exactly when bram_dout is valid; bram_dout is then written into the FIFO together with its last flag.
- Stream output: m_tvalid = FIFO not empty; m_tdata/m_tlast come from the FIFO head. A beat transfers when m_tvalid&&m_tready. m_tdata and m_tlast stay stable while m_tvalid=1 and m_tready=0.
- FIFO simultaneous push/pop in the same cycle is legal; the count is unchanged.
- Credit rule: an issued read always has a FIFO slot, so the FIFO never overflows.
- Latency: start accepted at edge 0 → first bram_en in cycle 1 → FIFO write at edge 1+READ_LATENCY → m_tvalid=1 in cycle 2+READ_LATENCY.
- Throughput: with m_tready held high, one word per cycle, no bubbles after the first.
- Completion: done pulses and busy falls in the cycle after the m_tlast beat transfers.
- Abort (any state): next cycle FSM=IDLE, FIFO emptied, in-flight flags cleared, m_tvalid=0, busy=0, no done. Abort has priority over start in the same cycle.
- Address wrap: start_addr=2^ADDR_WIDTH-1 with num_words=3 reads 1023, 0, 1 (ADDR_WIDTH=10).
- rst asserted mid-packet: everything returns to reset values immediately; the partial packet is discarded.

Test Plan:
1. READ_LATENCY=1, start_addr=16, num_words=4, m_tready=1: bram_addr 16..19 in cycles 1..4; m_tvalid cycles 3..6 with data mem[16..19]; m_tlast only in cycle 6; done pulse and busy low in cycle 7.
2. Backpressure: num_words=8, m_tready toggled 1,0,0,1 repeating: all 8 words delivered in order with no drop or duplicate; fifo_count never exceeds FIFO_DEPTH; bram_en stalls while credit is exhausted.
3. Wrap: start_addr=1022, num_words=4: addresses 1022, 1023, 0, 1; data order preserved.
4. num_words=0: done pulses in cycle 1, busy stays 0, bram_en never asserts, m_tvalid stays 0. A start while busy (during scenario 1) is ignored.
5. abort in cycle 4 of an 8-word packet with m_tready=0: cycle 5 has m_tvalid=0, busy=0, bram_en=0, no done pulse. A following packet (start_addr=0, num_words=2) delivers mem[0], mem[1] correctly.
6. READ_LATENCY=3, num_words=5, m_tready=1: first m_tvalid in cycle 5, then 5 contiguous beats. Asserting rst in the middle clears all outputs asynchronously.

Source files
------------

// File: rtl/tx_bram_pkt_reader.sv
// ============================================================================
// tx_bram_pkt_reader
//   Drains a NUM-word packet from the TX packet BRAM read port into a
//   valid/ready stream, using a credit-controlled skid FIFO.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tx_bram_pkt_reader #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH:0]     remaining;
  logic [READ_LATENCY-1:0] flt_valid;
  logic [READ_LATENCY-1:0] flt_last;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           fifo_count;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last;

  logic issue, issue_last, push, pop, credit, drain_done, accept, zero_start;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CW'(flt_valid[i]);
    end
  end

  // A read is only issued when a FIFO slot is guaranteed for its data.
  assign credit     = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
  assign issue      = (state == READ) && (remaining != '0) && credit;
  assign issue_last = issue && (remaining == (ADDR_WIDTH + 1)'(1));
  assign push       = flt_valid[READ_LATENCY-1];
  assign pop        = m_tvalid && m_tready;
  assign drain_done = (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));
  assign accept     = (state == IDLE) && start && (num_words != '0);
  assign zero_start = (state == IDLE) && start && (num_words == '0);

  assign busy      = (state != IDLE);
  assign bram_en   = issue;
  assign bram_addr = addr;
  assign m_tvalid  = (fifo_count != '0);
  assign m_tdata   = m_tvalid ? fifo_data[rd_ptr] : '0;
  assign m_tlast   = m_tvalid && fifo_last[rd_ptr];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = READ;
      READ:    if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      remaining  <= '0;
      flt_valid  <= '0;
      flt_last   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      done       <= 1'b0;
    end else if (abort) begin
      remaining  <= '0;
      flt_valid  <= '0;
      flt_last   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      done       <= 1'b0;
    end else begin
      done <= zero_start || ((state == DRAIN) && drain_done);
      if (accept) begin
        addr      <= start_addr;
        remaining <= num_words;
      end else if (issue) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      flt_valid <= (flt_valid << 1) | READ_LATENCY'(issue);
      flt_last  <= (flt_last << 1)  | READ_LATENCY'(issue_last);
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage is not reset; the output mux gates it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !abort) begin
      fifo_data[wr_ptr] <= bram_dout;
      fifo_last[wr_ptr] <= flt_last[READ_LATENCY-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tx_bram_pkt_reader.sv
// ============================================================================
// tb_tx_bram_pkt_reader
//   Scoreboard bench: two instances (read latency 1 and 3) with BRAM models.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tx_bram_pkt_reader;

  localparam int DW = 64;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, start_a, abort_a, busy_a, done_a, en_a, tv_a, tr_a, tl_a;
  logic [AW-1:0] sa_a, addr_a;
  logic [AW:0]   nw_a;
  logic [DW-1:0] dout_a, td_a;

  logic          rst_b, start_b, abort_b, busy_b, done_b, en_b, tv_b, tr_b, tl_b;
  logic [AW-1:0] sa_b, addr_b;
  logic [AW:0]   nw_b;
  logic [DW-1:0] dout_b, td_b, p1_b, p2_b;

  tx_bram_pkt_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .start_addr(sa_a), .num_words(nw_a),
    .abort(abort_a), .busy(busy_a), .done(done_a), .bram_en(en_a), .bram_addr(addr_a),
    .bram_dout(dout_a), .m_tdata(td_a), .m_tvalid(tv_a), .m_tready(tr_a), .m_tlast(tl_a)
  );

  tx_bram_pkt_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .start_addr(sa_b), .num_words(nw_b),
    .abort(abort_b), .busy(busy_b), .done(done_b), .bram_en(en_b), .bram_addr(addr_b),
    .bram_dout(dout_b), .m_tdata(td_b), .m_tvalid(tv_b), .m_tready(tr_b), .m_tlast(tl_b)
  );

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {16'hC0DE, 6'h2A, a, 22'h155555, ~a};
  endfunction

  always @(posedge clk) if (en_a) dout_a <= memf(addr_a);
  always @(posedge clk) begin
    p1_b   <= memf(addr_b);
    p2_b   <= p1_b;
    dout_b <= p2_b;
  end

  int checks = 0;
  int errors = 0;
  logic [DW:0] q_a[$];
  logic [DW:0] q_b[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input bit b, input int sa, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = AW'(sa + i);
      if (b) q_b.push_back({(i == n - 1), memf(a)});
      else   q_a.push_back({(i == n - 1), memf(a)});
    end
  endtask

  // Monitors: pop and compare every transferred beat.
  always @(negedge clk) begin
    if (!rst_a && tv_a && tr_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_beat actual=%0h required=none", {tl_a, td_a});
      end else chk("a_beat", {tl_a, td_a}, q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst_b && tv_b && tr_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_beat actual=%0h required=none", {tl_b, td_b});
      end else chk("b_beat", {tl_b, td_b}, q_b.pop_front());
    end
  end

  // Leaves the bench just after edge 0 with start already released (cycle 1).
  task automatic kick(input bit b, input int sa, input int n);
    @(posedge clk); #1;
    if (b) begin start_b = 1'b1; sa_b = AW'(sa); nw_b = (AW + 1)'(n); end
    else   begin start_a = 1'b1; sa_a = AW'(sa); nw_a = (AW + 1)'(n); end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit b, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (b ? done_b : done_a) begin
        seen = 1'b1;
        chk("busy_low_at_done", b ? busy_b : busy_a, 0);
      end
    end
    chk("done_within_budget", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued, popped;
    bit stalled, dseen;
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; sa_a = '0; nw_a = '0; tr_a = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; sa_b = '0; nw_b = '0; tr_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_en", en_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_tvalid", tv_a, 0);
    chk("rst_tlast", tl_a, 0);
    chk("rst_tdata", td_a, 0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Basic 4-word packet; a second start while busy must be ignored.
    push_pkt(0, 16, 4);
    kick(0, 16, 4);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 2) begin start_a = 1'b1; sa_a = 10'd500; nw_a = 11'd2; end
      if (k == 3) start_a = 1'b0;
      @(negedge clk);
      chk("t1_en", en_a, k <= 4);
      if (k <= 4) chk("t1_addr", addr_a, 16 + k - 1);
      chk("t1_tvalid", tv_a, (k >= 3) && (k <= 6));
      chk("t1_tlast", tl_a, k == 6);
      chk("t1_done", done_a, k == 7);
      chk("t1_busy", busy_a, k <= 6);
    end
    start_a = 1'b0;

    // Zero-length packet.
    kick(0, 5, 0);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("t4_done", done_a, k == 1);
      chk("t4_busy", busy_a, 0);
      chk("t4_en", en_a, 0);
      chk("t4_tvalid", tv_a, 0);
    end

    // Backpressure with ready pattern 1,0,0,1.
    push_pkt(0, 100, 8);
    kick(0, 100, 8);
    issued = 0; popped = 0; stalled = 1'b0; dseen = 1'b0;
    for (int k = 1; k <= 80 && !dseen; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      tr_a = ((k % 4) == 1) || ((k % 4) == 0);
      @(negedge clk);
      if (en_a) issued++;
      chk("t2_credit", (issued - popped) <= 3, 1);
      if (busy_a && !en_a && issued < 8) stalled = 1'b1;
      if (tv_a && tr_a) popped++;
      if (done_a) dseen = 1'b1;
    end
    chk("t2_done_seen", dseen, 1);
    chk("t2_popped", popped, 8);
    chk("t2_issued", issued, 8);
    chk("t2_stalled", stalled, 1);
    chk("t2_queue_empty", q_a.size(), 0);
    @(posedge clk); #1;
    tr_a = 1'b1;

    // Address wrap.
    push_pkt(0, 1022, 4);
    kick(0, 1022, 4);
    for (int k = 1; k <= 4; k++) begin
      logic [AW-1:0] ea;
      ea = AW'(1022 + k - 1);
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("t3_en", en_a, 1);
      chk("t3_addr", addr_a, ea);
    end
    wait_done(0, 20);
    chk("t3_queue_empty", q_a.size(), 0);

    // Abort in cycle 4 with the stream stalled, then a clean 2-word packet.
    tr_a = 1'b0;
    kick(0, 200, 8);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      abort_a = (k == 4);
      @(negedge clk);
      if (k == 4) chk("t5_tvalid_before", tv_a, 1);
      if (k >= 5) begin
        chk("t5_tvalid", tv_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_en", en_a, 0);
        chk("t5_done", done_a, 0);
      end
    end
    tr_a = 1'b1;
    push_pkt(0, 0, 2);
    kick(0, 0, 2);
    wait_done(0, 20);
    chk("t5_queue_empty", q_a.size(), 0);

    // Read latency 3: 5 contiguous beats.
    push_pkt(1, 40, 5);
    kick(1, 40, 5);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("t6_en", en_b, k <= 5);
      chk("t6_tvalid", tv_b, (k >= 5) && (k <= 9));
      chk("t6_tlast", tl_b, k == 9);
      chk("t6_done", done_b, k == 10);
      chk("t6_busy", busy_b, k <= 9);
    end

    // Asynchronous reset in the middle of a packet.
    push_pkt(1, 60, 5);
    kick(1, 60, 5);
    repeat (5) @(negedge clk);
    #2 rst_b = 1'b1;
    #1;
    chk("t6_rst_busy", busy_b, 0);
    chk("t6_rst_done", done_b, 0);
    chk("t6_rst_en", en_b, 0);
    chk("t6_rst_addr", addr_b, 0);
    chk("t6_rst_tvalid", tv_b, 0);
    chk("t6_rst_tlast", tl_b, 0);
    chk("t6_rst_tdata", td_b, 0);
    q_b.delete();
    @(posedge clk); #1;
    rst_b = 1'b0;
    push_pkt(1, 7, 1);
    kick(1, 7, 1);
    wait_done(1, 20);
    chk("t6_queue_empty", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
